// File: rtl/mem_sram_ctrl_pkg.sv
// Shared encodings for the SRAM bank controller: access sizes,
// FSM states, bank-field bit range and an alignment helper.
package mem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   localparam int BANK_HI = 15;
   localparam int BANK_LO = 13;

   typedef enum logic [2:0] {
      IDLE,
      ACC,
      LATCH,
      RMW_RD,
      RMW_MRG,
      RMW_WR
   } state_t;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] off
   );
      return (size == SIZE_X)
          || (size == SIZE_H && off[0])
          || (size == SIZE_W && off != 2'b00);
   endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Requester channel: valid/ready request plus one-cycle response.
// master = requester (IF or LSU), slave = controller.
interface mem_req_if;

   logic        req_valid;
   logic        req_ready;
   logic [15:0] addr;
   logic        wen;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output req_valid, addr, wen, size, sext, wdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, addr, wen, size, sext, wdata,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/mem_sram_ctrl_lane.sv
// Lane formatter: load extract/extend from a bank word, and
// sub-word store merge into a bank word. Purely combinational.
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [31:0] dout,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   logic [31:0] shifted;
   logic [31:0] mask;
   logic [31:0] rep;

   always_comb begin
      shifted = dout >> {off, 3'b000};
      rdata   = dout;
      mask    = '1;
      rep     = wdata;
      case (size)
         SIZE_B: begin
            rdata = {{24{sext & shifted[7]}}, shifted[7:0]};
            mask  = 32'h0000_00FF << {off, 3'b000};
            rep   = {4{wdata[7:0]}};
         end
         SIZE_H: begin
            rdata = {{16{sext & shifted[15]}}, shifted[15:0]};
            mask  = 32'h0000_FFFF << {off[1], 4'b0000};
            rep   = {2{wdata[15:0]}};
         end
         default: ;
      endcase
      merged = (dout & ~mask) | (rep & mask);
   end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Shares one SRAM bank between IF (ifr) and LS (lsr) requesters.
// Ports: clk, rst_n, ifr/lsr channels, sram_* bank interface.
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter logic [2:0] BANK_SEL   = 3'd0,
   parameter int         STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_req_if.slave    ifr,
   mem_req_if.slave    lsr,
   output logic        sram_en,
   output logic        sram_wen,
   output logic [2:0]  sram_cs,
   output logic [12:0] sram_addr,
   output logic [1:0]  sram_size,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   state_t        state;
   logic [SW-1:0] streak;
   logic          cap_ls;
   logic          cap_wen;
   logic          cap_sext;
   logic [1:0]    cap_size;
   logic [1:0]    cap_off;

   logic          idle;
   logic          grant_if;
   logic          grant_ls;
   logic          take;
   logic [15:0]   req_addr;
   logic          req_wen;
   logic [1:0]    req_size;
   logic          req_sext;
   logic [31:0]   req_wdata;
   logic          req_err;
   logic [31:0]   rdata;
   logic [31:0]   merged;

   assign sram_cs = BANK_SEL;

   // LS wins contention unless IF has waited STARVE_MAX grants.
   assign idle     = (state == IDLE);
   assign grant_ls = idle & lsr.req_valid
                   & ~(ifr.req_valid & (streak == SMAX));
   assign grant_if = idle & ifr.req_valid & ~grant_ls;
   assign take     = grant_ls | grant_if;

   assign lsr.req_ready = grant_ls;
   assign ifr.req_ready = grant_if;

   always_comb begin
      req_addr  = ifr.addr;
      req_wen   = 1'b0;
      req_size  = SIZE_W;
      req_sext  = 1'b0;
      req_wdata = '0;
      if (grant_ls) begin
         req_addr  = lsr.addr;
         req_wen   = lsr.wen;
         req_size  = lsr.size;
         req_sext  = lsr.sext;
         req_wdata = lsr.wdata;
      end
   end

   assign req_err = (req_addr[BANK_HI:BANK_LO] != BANK_SEL)
                  | misaligned(req_size, req_addr[1:0]);

   // sram_din holds the store data until the merge overwrites it.
   mem_lane_fmt u_lane (
      .dout   (sram_dout),
      .off    (cap_off),
      .size   (cap_size),
      .sext   (cap_sext),
      .wdata  (sram_din),
      .rdata  (rdata),
      .merged (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         streak        <= '0;
         cap_ls        <= 1'b0;
         cap_wen       <= 1'b0;
         cap_sext      <= 1'b0;
         cap_size      <= SIZE_W;
         cap_off       <= 2'b00;
         sram_en       <= 1'b0;
         sram_wen      <= 1'b0;
         sram_addr     <= '0;
         sram_size     <= SIZE_W;
         sram_din      <= '0;
         ifr.rsp_valid <= 1'b0;
         ifr.rsp_err   <= 1'b0;
         ifr.rsp_data  <= '0;
         lsr.rsp_valid <= 1'b0;
         lsr.rsp_err   <= 1'b0;
         lsr.rsp_data  <= '0;
      end else begin
         sram_en       <= 1'b0;
         sram_wen      <= 1'b0;
         ifr.rsp_valid <= 1'b0;
         ifr.rsp_err   <= 1'b0;
         lsr.rsp_valid <= 1'b0;
         lsr.rsp_err   <= 1'b0;
         unique case (state)
            IDLE: if (take) begin
               cap_ls    <= grant_ls;
               cap_wen   <= req_wen;
               cap_sext  <= req_sext;
               cap_size  <= req_size;
               cap_off   <= req_addr[1:0];
               sram_addr <= {req_addr[12:2], 2'b00};
               sram_din  <= req_wdata;
               sram_size <= SIZE_W;
               if (grant_if) begin
                  streak <= '0;
               end else if (ifr.req_valid) begin
                  streak <= streak + 1'b1;
               end
               if (req_err) begin
                  if (grant_ls) begin
                     lsr.rsp_valid <= 1'b1;
                     lsr.rsp_err   <= 1'b1;
                     lsr.rsp_data  <= '0;
                  end else begin
                     ifr.rsp_valid <= 1'b1;
                     ifr.rsp_err   <= 1'b1;
                     ifr.rsp_data  <= '0;
                  end
               end else if (!req_wen) begin
                  sram_en <= 1'b1;
                  state   <= ACC;
               end else if (req_addr[1:0] == 2'b00) begin
                  sram_en   <= 1'b1;
                  sram_wen  <= 1'b1;
                  sram_size <= req_size;
                  state     <= ACC;
               end else begin
                  sram_en <= 1'b1;
                  state   <= RMW_RD;
               end
            end
            ACC: begin
               if (cap_wen) begin
                  lsr.rsp_valid <= 1'b1;
                  lsr.rsp_data  <= '0;
                  state         <= IDLE;
               end else begin
                  state <= LATCH;
               end
            end
            LATCH: begin
               if (cap_ls) begin
                  lsr.rsp_valid <= 1'b1;
                  lsr.rsp_data  <= rdata;
               end else begin
                  ifr.rsp_valid <= 1'b1;
                  ifr.rsp_data  <= rdata;
               end
               state <= IDLE;
            end
            RMW_RD: state <= RMW_MRG;
            RMW_MRG: begin
               sram_din  <= merged;
               sram_en   <= 1'b1;
               sram_wen  <= 1'b1;
               sram_size <= SIZE_W;
               state     <= RMW_WR;
            end
            RMW_WR: begin
               lsr.rsp_valid <= 1'b1;
               lsr.rsp_data  <= '0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
